// File: rtl/jpegls_ctx_pkg.sv
// Shared JPEG-LS context pipeline definitions: field widths, context count,
// the per-context record and the store's state encoding.
package jpegls_ctx_pkg;

    localparam int Q_LENGTH  = 9;
    localparam int NUM_CTX   = 367;
    localparam int A_LENGTH  = 16;
    localparam int B_LENGTH  = 7;
    localparam int C_LENGTH  = 8;
    localparam int N_LENGTH  = 7;
    localparam int NN_LENGTH = 7;

    localparam logic [A_LENGTH-1:0] A_INIT  = A_LENGTH'(4);
    localparam logic [Q_LENGTH-1:0] LAST_Q  = Q_LENGTH'(NUM_CTX - 1);
    localparam logic [Q_LENGTH-1:0] NUM_CTX_Q = Q_LENGTH'(NUM_CTX);

    typedef struct packed {
        logic        [A_LENGTH-1:0]  a;
        logic signed [B_LENGTH-1:0]  b;
        logic signed [C_LENGTH-1:0]  c;
        logic        [N_LENGTH-1:0]  n;
        logic        [NN_LENGTH-1:0] nn;
    } ctx_rec_t;

    localparam ctx_rec_t CTX_INIT = '{a: A_INIT, b: '0, c: '0, n: N_LENGTH'(1), nn: '0};

    typedef enum logic {
        ST_INIT,
        ST_READY
    } ctx_state_t;

    function automatic logic q_in_range(input logic [Q_LENGTH-1:0] q);
        return q < NUM_CTX_Q;
    endfunction

endpackage

// File: rtl/context_ram.sv
// Record-wide 1R1W context memory with a registered read port. A same-address
// read and write in one cycle returns the old contents; the caller forwards.
module context_ram
    import jpegls_ctx_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [Q_LENGTH-1:0] waddr,
    input  ctx_rec_t            wdata,
    input  logic                re,
    input  logic [Q_LENGTH-1:0] raddr,
    output ctx_rec_t            rdata
);

    ctx_rec_t mem [NUM_CTX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/context_store_writeback.sv
// Context store for the JPEG-LS pipeline: sweeps every context to its initial
// value, then serves 1-cycle reads kept coherent against write-back traffic.
module context_store_writeback
    import jpegls_ctx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_req,
    output logic                 ready,
    input  logic                 rd_en,
    input  logic [Q_LENGTH-1:0]  rd_q,
    output logic                 rd_valid,
    output logic [Q_LENGTH-1:0]  rd_q_out,
    output logic [A_LENGTH-1:0]  rd_a,
    output logic [B_LENGTH-1:0]  rd_b,
    output logic [C_LENGTH-1:0]  rd_c,
    output logic [N_LENGTH-1:0]  rd_n,
    output logic [NN_LENGTH-1:0] rd_nn,
    output logic                 rd_bypass,
    input  logic                 wr_en,
    input  logic [Q_LENGTH-1:0]  wr_q,
    input  logic [A_LENGTH-1:0]  wr_a,
    input  logic [B_LENGTH-1:0]  wr_b,
    input  logic [C_LENGTH-1:0]  wr_c,
    input  logic [N_LENGTH-1:0]  wr_n,
    input  logic [NN_LENGTH-1:0] wr_nn,
    output logic                 addr_err
);

    ctx_state_t          state_q, state_d;
    logic [Q_LENGTH-1:0] init_cnt_q;

    logic                ram_we, ram_re;
    logic [Q_LENGTH-1:0] ram_waddr;
    ctx_rec_t            ram_wdata, ram_rdata;

    ctx_rec_t            wr_rec, byp_q, rd_rec;
    logic                use_ram_q, held_q;
    logic                rd_acc, wr_acc, rd_ok, wr_ok;

    assign wr_rec = {wr_a, wr_b, wr_c, wr_n, wr_nn};
    assign rd_ok  = q_in_range(rd_q);
    assign wr_ok  = q_in_range(wr_q);
    assign rd_acc = (state_q == ST_READY) && rd_en;
    assign wr_acc = (state_q == ST_READY) && wr_en;
    assign ram_re = rd_acc && rd_ok;
    assign ready  = (state_q == ST_READY);

    // During INIT the write port belongs to the sweep; otherwise to write-back
    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_waddr = wr_q;
        ram_wdata = wr_rec;
        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_cnt_q;
                ram_wdata = CTX_INIT;
                if (init_cnt_q == LAST_Q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                ram_we = wr_acc && wr_ok;
                if (init_req) begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= (state_q == ST_INIT) ? init_cnt_q + Q_LENGTH'(1) : '0;
        end
    end

    context_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_q),
        .rdata (ram_rdata)
    );

    // Output data comes from the RAM register unless a forwarded or zeroed
    // record has been captured; held_q marks that the held index is real.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_q_out  <= '0;
            rd_bypass <= 1'b0;
            addr_err  <= 1'b0;
            use_ram_q <= 1'b0;
            held_q    <= 1'b0;
            byp_q     <= '0;
        end else begin
            rd_valid <= rd_acc;
            addr_err <= (rd_acc && !rd_ok) || (wr_acc && !wr_ok);
            if (rd_acc) begin
                rd_q_out <= rd_q;
                held_q   <= rd_ok;
                if (!rd_ok) begin
                    use_ram_q <= 1'b0;
                    byp_q     <= '0;
                    rd_bypass <= 1'b0;
                end else if (wr_acc && (wr_q == rd_q)) begin
                    use_ram_q <= 1'b0;
                    byp_q     <= wr_rec;
                    rd_bypass <= 1'b1;
                end else begin
                    use_ram_q <= 1'b1;
                    rd_bypass <= 1'b0;
                end
            end else if (wr_acc && wr_ok && held_q && (wr_q == rd_q_out)) begin
                use_ram_q <= 1'b0;
                byp_q     <= wr_rec;
                rd_bypass <= 1'b1;
            end
        end
    end

    assign rd_rec = use_ram_q ? ram_rdata : byp_q;
    assign rd_a   = rd_rec.a;
    assign rd_b   = rd_rec.b;
    assign rd_c   = rd_rec.c;
    assign rd_n   = rd_rec.n;
    assign rd_nn  = rd_rec.nn;

endmodule

// File: tb/tb_context_store_writeback.sv
// Directed bench for context_store_writeback: init timing, read/write paths,
// forwarding, out-of-range handling and re-initialisation.
module tb_context_store_writeback;

    localparam int          NCTX     = 367;
    localparam logic [44:0] INIT_REC = {16'd4, 7'd0, 8'd0, 7'd1, 7'd0};

    logic        clk = 1'b0;
    logic        rst, init_req, ready;
    logic        rd_en, rd_valid, rd_bypass, wr_en, addr_err;
    logic [8:0]  rd_q, rd_q_out, wr_q;
    logic [15:0] rd_a, wr_a;
    logic [6:0]  rd_b, wr_b, rd_n, wr_n, rd_nn, wr_nn;
    logic [7:0]  rd_c, wr_c;

    int          errors = 0;
    int          checks = 0;
    logic [44:0] model [NCTX];

    context_store_writeback dut (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(ready),
        .rd_en(rd_en), .rd_q(rd_q), .rd_valid(rd_valid), .rd_q_out(rd_q_out),
        .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c), .rd_n(rd_n), .rd_nn(rd_nn),
        .rd_bypass(rd_bypass), .wr_en(wr_en), .wr_q(wr_q),
        .wr_a(wr_a), .wr_b(wr_b), .wr_c(wr_c), .wr_n(wr_n), .wr_nn(wr_nn),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelInit();
        for (int i = 0; i < NCTX; i++) model[i] = INIT_REC;
    endtask

    // One clock with the given request pair; the model tracks in-range writes
    task automatic applyStimulus(input logic r_en, input logic [8:0] r_q,
                                 input logic w_en, input logic [8:0] w_q,
                                 input logic [44:0] w_rec);
        rd_en = r_en;
        rd_q  = r_q;
        wr_en = w_en;
        wr_q  = w_q;
        {wr_a, wr_b, wr_c, wr_n, wr_nn} = w_rec;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (w_en && (w_q < 9'(NCTX)) && ready) model[w_q] = w_rec;
    endtask

    task automatic readCheck(input string tag, input logic [8:0] q);
        applyStimulus(1'b1, q, 1'b0, 9'd0, 45'd0);
        checkOutput({tag, "_valid"}, rd_valid, 1'b1);
        checkOutput({tag, "_qout"}, rd_q_out, q);
        checkOutput({tag, "_data"}, {rd_a, rd_b, rd_c, rd_n, rd_nn}, model[q]);
        checkOutput({tag, "_bypass"}, rd_bypass, 1'b0);
    endtask

    task automatic waitReady(input string tag, input int exp_cycles);
        int n = 0;
        while (!ready && n < 1000) begin
            tick();
            n++;
        end
        checkOutput(tag, n, exp_cycles);
    endtask

    initial begin
        rst = 1'b1; init_req = 1'b0; rd_en = 1'b0; rd_q = '0; wr_en = 1'b0; wr_q = '0;
        {wr_a, wr_b, wr_c, wr_n, wr_nn} = '0;
        modelInit();
        tick();
        tick();
        checkOutput("rst_ready", ready, 1'b0);
        checkOutput("rst_valid", rd_valid, 1'b0);
        checkOutput("rst_qout", rd_q_out, 9'd0);
        checkOutput("rst_data", {rd_a, rd_b, rd_c, rd_n, rd_nn}, 45'd0);
        checkOutput("rst_bypass", rd_bypass, 1'b0);
        checkOutput("rst_addr_err", addr_err, 1'b0);

        rst = 1'b0;
        waitReady("init_len", 367);
        readCheck("init_q0", 9'd0);
        readCheck("init_q200", 9'd200);
        readCheck("init_q366", 9'd366);
        applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 45'd0);
        checkOutput("hold_valid", rd_valid, 1'b0);
        checkOutput("hold_qout", rd_q_out, 9'd366);
        checkOutput("hold_data", {rd_a, rd_b, rd_c, rd_n, rd_nn}, INIT_REC);

        // A=300 B=-3 C=-128 N=64 Nn=5
        applyStimulus(1'b0, 9'd0, 1'b1, 9'd17, {16'd300, 7'h7D, 8'h80, 7'd64, 7'd5});
        readCheck("wr17", 9'd17);
        checkOutput("wr17_b_neg", rd_b, 7'h7D);

        applyStimulus(1'b1, 9'd42, 1'b1, 9'd42, {16'd99, 7'd1, 8'd2, 7'd3, 7'd4});
        checkOutput("fwd42_valid", rd_valid, 1'b1);
        checkOutput("fwd42_a", rd_a, 16'd99);
        checkOutput("fwd42_bypass", rd_bypass, 1'b1);
        applyStimulus(1'b1, 9'd42, 1'b1, 9'd43, {16'd55, 7'd0, 8'd0, 7'd1, 7'd0});
        checkOutput("nofwd42_a", rd_a, 16'd99);
        checkOutput("nofwd42_bypass", rd_bypass, 1'b0);
        readCheck("rd43", 9'd43);

        readCheck("held5", 9'd5);
        applyStimulus(1'b0, 9'd0, 1'b1, 9'd6, {16'd66, 7'd0, 8'd0, 7'd1, 7'd0});
        checkOutput("other_wr_data", {rd_a, rd_b, rd_c, rd_n, rd_nn}, INIT_REC);
        checkOutput("other_wr_bypass", rd_bypass, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1, 9'd5, {16'd10, 7'd0, 8'd7, 7'd1, 7'd0});
        checkOutput("held5_c", rd_c, 8'd7);
        checkOutput("held5_data", {rd_a, rd_b, rd_c, rd_n, rd_nn}, model[5]);
        checkOutput("held5_bypass", rd_bypass, 1'b1);
        checkOutput("held5_valid", rd_valid, 1'b0);

        applyStimulus(1'b0, 9'd0, 1'b1, 9'd400, {16'd777, 7'd1, 8'd1, 7'd1, 7'd1});
        checkOutput("bad_wr_err", addr_err, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 45'd0);
        checkOutput("err_clear", addr_err, 1'b0);
        applyStimulus(1'b1, 9'd400, 1'b0, 9'd0, 45'd0);
        checkOutput("bad_rd_err", addr_err, 1'b1);
        checkOutput("bad_rd_valid", rd_valid, 1'b1);
        checkOutput("bad_rd_qout", rd_q_out, 9'd400);
        checkOutput("bad_rd_data", {rd_a, rd_b, rd_c, rd_n, rd_nn}, 45'd0);
        checkOutput("bad_rd_bypass", rd_bypass, 1'b0);
        applyStimulus(1'b1, 9'd450, 1'b1, 9'd500, {16'd888, 7'd2, 8'd2, 7'd2, 7'd2});
        checkOutput("both_bad_err", addr_err, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 45'd0);
        checkOutput("both_bad_single", addr_err, 1'b0);
        for (int q = 0; q < NCTX; q++) readCheck("sweep", 9'(q));

        // Reset part-way through a fresh init, with traffic that must be ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (99) tick();
        applyStimulus(1'b1, 9'd3, 1'b1, 9'd400, {16'd1, 7'd1, 7'd1, 8'd1, 7'd1});
        checkOutput("init_ready", ready, 1'b0);
        checkOutput("init_no_valid", rd_valid, 1'b0);
        checkOutput("init_no_err", addr_err, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelInit();
        checkOutput("rerst_data", {rd_a, rd_b, rd_c, rd_n, rd_nn}, 45'd0);
        waitReady("rerst_len", 367);

        applyStimulus(1'b0, 9'd0, 1'b1, 9'd3, {16'd123, 7'd9, 8'd9, 7'd9, 7'd9});
        readCheck("wr3", 9'd3);
        init_req = 1'b1;
        applyStimulus(1'b1, 9'd3, 1'b0, 9'd0, 45'd0);
        init_req = 1'b0;
        checkOutput("initreq_rd_valid", rd_valid, 1'b1);
        checkOutput("initreq_rd_a", rd_a, 16'd123);
        checkOutput("initreq_ready", ready, 1'b0);
        modelInit();
        waitReady("initreq_len", 367);
        readCheck("reinit_q3", 9'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/context_store_writeback.md
Name: context_store_writeback

Overview:
- Context memory and write-back end of the JPEG-LS context pipeline.
- Holds A/B/C/N/Nn for every context.
- Initialises all entries after reset and accepts write-back of updated context variables from the update stage.
- Serves the stage-4 read with a 1-cycle registered latency, and keeps read data coherent against same-address writes, so the downstream selector receives current values.

Parameters:
- Q_LENGTH, 9, context index width
- NUM_CTX, 367, number of contexts (365 regular + 2 run-interruption)
- A_LENGTH, 16, A accumulator width (unsigned)
- B_LENGTH, 7, B width (two's complement)
- C_LENGTH, 8, C width (two's complement)
- N_LENGTH, 7, N counter width (unsigned)
- NN_LENGTH, 7, Nn counter width (unsigned)
- A_INIT, 4, A reset value, max(2,(RANGE+32)/64) for 8-bit

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- init_req  in  1  request re-initialisation of all contexts (honoured only in READY)
- ready  out  1  high when init complete and ports accepted
- rd_en  in  1  read request
- rd_q  in  Q_LENGTH  read context index
- rd_valid  out  1  rd_* data valid (1 cycle after accepted rd_en)
- rd_q_out  out  Q_LENGTH  index of held read data
- rd_a / rd_b / rd_c / rd_n / rd_nn  out  per-field widths  read context variables
- rd_bypass  out  1  held data came from same-cycle or later write forwarding
- wr_en  in  1  write-back request
- wr_q  in  Q_LENGTH  write context index
- wr_a / wr_b / wr_c / wr_n / wr_nn  in  per-field widths  updated context variables
- addr_err  out  1  1-cycle pulse when an accepted rd/wr index is >= NUM_CTX

Behaviour:
- Reset values: ready=0, rd_valid=0, rd_q_out=0, rd_a..rd_nn=0, rd_bypass=0, addr_err=0.
- FSM states INIT and READY.
- rst forces INIT with init counter=0, from any state, including mid-init or mid-traffic.
- INIT:
  - Each cycle writes counter entry with A=A_INIT, B=0, C=0, N=1, Nn=0, then increments the counter.
  - After entry NUM_CTX-1 is written, go to READY next cycle; init takes exactly NUM_CTX cycles.
  - rd_en and wr_en are ignored; rd_valid=0; addr_err=0.
- READY:
  - ready=1.
  - init_req=1 → INIT next cycle. Any rd_en/wr_en in that same cycle is still serviced.
- Read:
  - rd_en at cycle t in READY → rd_valid=1 at t+1, with rd_q_out=rd_q and data from memory.
  - Without rd_en at t, rd_valid=0 at t+1, and rd data/rd_q_out hold their previous values.
- Write: wr_en at t in READY updates the entry at the t edge; the value is visible to reads from t+1.
- Simultaneous rd_en and wr_en to the same index at t (write-first): rd data at t+1 = wr data, rd_bypass=1.
- Held-data coherence: if rd_valid or held data is for index X and wr_en hits X at t, outputs show the written values at t+1 with rd_bypass=1. rd_valid stays 0 unless a new rd_en occurred.
- rd_bypass=0 whenever data comes from memory.
- Out-of-range index (>= NUM_CTX):
  - A write is dropped.
  - A read returns all-zero fields with rd_valid=1.
  - addr_err pulses at t+1. One pulse is produced if both rd and wr are bad.
- Widths: fields are stored verbatim with no arithmetic. B and C keep two's-complement sign; N/Nn are unsigned.

Decomposition:
- Shared package (jpegls_ctx_pkg): the field-width constants, NUM_CTX, A_INIT, and a context-record typedef {A,B,C,N,Nn} used by this block and the mux/update stages.
- One sub-module, context_ram: 1R1W synchronous RAM, depth NUM_CTX, record-wide, registered read, no internal bypass.
- The FSM, init counter, bypass comparators and range checks live in the top.

Test Plan:
- Reset then idle → ready=0 for 367 cycles, ready=1 on cycle 368. Reading Q=0, 200 and 366 returns A=4, B=0, C=0, N=1, Nn=0.
- Write Q=17 with A=300, B=-3, C=-128, N=64, Nn=5, then read Q=17 next cycle → those values at t+2, rd_bypass=0.
- Same-cycle rd_en/wr_en on Q=42, wr A=99 → at t+1 rd_a=99, rd_bypass=1. Same with rd Q=42, wr Q=43 → memory value, rd_bypass=0.
- Read Q=5 (held), then write Q=5 with C=7 one cycle later → rd_c=7 next cycle, rd_bypass=1, rd_valid=0.
- wr Q=400 then rd Q=400 → addr_err pulses for each. Read returns zeros with rd_valid=1, and no entry is modified (Q=400 mod 512 aliasing check on Q=0..366).
- Assert rst during traffic at init counter 100, then init_req in READY after writing Q=3 → both re-run the full 367-cycle init. Q=3 reads back initial values.
